// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//   Multicycle control sequencer for the ezRISC datapath. Fetches through
//   F0/F1/F2, then walks execute steps T3..T7 decoded from the 5-bit opcode
//   at the top of the instruction register. Adds memory wait states with a
//   timeout, single-step debug mode and halt/resume with sticky fault flags.
//
// Ports
//   i_clk, reset_n        clock, asynchronous active-low reset
//   i_ir_data             instruction register (opcode = top 5 bits)
//   i_con_ff              branch condition
//   i_mem_ready           memory completes the pending read/write this cycle
//   i_stop / i_resume     synchronous halt request / leave HALT
//   i_step_en / i_step_req single-step mode / advance one instruction
//   o_<strobe>            datapath strobes, Moore-decoded from state/step/opcode
//   o_alu_op              ALU operation select
//   o_run, o_retired      not halted / last-step pulse of an instruction
//   o_icount              retired-instruction count (wraps)
//   o_bus_error, o_illegal_op  sticky fault flags
//   o_dbg_state, o_dbg_step    FSM state and execute step for observation
//
// Memory handshake: a memory step (F1, ld T6, st T7) keeps its read/write
// strobe asserted and repeats every cycle until i_mem_ready is sampled high
// on a rising edge; that edge completes the transfer and leaves the step.
module ctrl_sequencer #(
  parameter int          IR_W   = 32,
  parameter int unsigned MEM_TO = 15,
  parameter int          ICNT_W = 32
) (
  input  logic              i_clk,
  input  logic              reset_n,
  input  logic [IR_W-1:0]   i_ir_data,
  input  logic              i_con_ff,
  input  logic              i_mem_ready,
  input  logic              i_stop,
  input  logic              i_resume,
  input  logic              i_step_en,
  input  logic              i_step_req,
  output logic              o_gra,
  output logic              o_grb,
  output logic              o_grc,
  output logic              o_r_in,
  output logic              o_r_out,
  output logic              o_ba_out,
  output logic              o_hi_in,
  output logic              o_hi_out,
  output logic              o_lo_in,
  output logic              o_lo_out,
  output logic              o_pc_in,
  output logic              o_pc_out,
  output logic              o_ir_in,
  output logic              o_z_in,
  output logic              o_z_high_out,
  output logic              o_z_low_out,
  output logic              o_inport_out,
  output logic              o_c_out,
  output logic              o_y_in,
  output logic              o_mar_in,
  output logic              o_outport_in,
  output logic              o_mdr_in,
  output logic              o_mdr_out,
  output logic              o_read,
  output logic              o_write,
  output logic              o_inc_pc,
  output logic              o_con_in,
  output logic [3:0]        o_alu_op,
  output logic              o_run,
  output logic              o_retired,
  output logic [ICNT_W-1:0] o_icount,
  output logic              o_bus_error,
  output logic              o_illegal_op,
  output logic [2:0]        o_dbg_state,
  output logic [2:0]        o_dbg_step
);

  typedef enum logic [2:0] {
    ST_BOUND = 3'd0,
    ST_F0    = 3'd1,
    ST_F1    = 3'd2,
    ST_F2    = 3'd3,
    ST_EX    = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  // Strobe masks; bit order matches the output assignment block below.
  localparam logic [26:0] M_GRA        = 27'd1 << 26;
  localparam logic [26:0] M_GRB        = 27'd1 << 25;
  localparam logic [26:0] M_GRC        = 27'd1 << 24;
  localparam logic [26:0] M_R_IN       = 27'd1 << 23;
  localparam logic [26:0] M_R_OUT      = 27'd1 << 22;
  localparam logic [26:0] M_BA_OUT     = 27'd1 << 21;
  localparam logic [26:0] M_HI_IN      = 27'd1 << 20;
  localparam logic [26:0] M_HI_OUT     = 27'd1 << 19;
  localparam logic [26:0] M_LO_IN      = 27'd1 << 18;
  localparam logic [26:0] M_LO_OUT     = 27'd1 << 17;
  localparam logic [26:0] M_PC_IN      = 27'd1 << 16;
  localparam logic [26:0] M_PC_OUT     = 27'd1 << 15;
  localparam logic [26:0] M_IR_IN      = 27'd1 << 14;
  localparam logic [26:0] M_Z_IN       = 27'd1 << 13;
  localparam logic [26:0] M_Z_HIGH_OUT = 27'd1 << 12;
  localparam logic [26:0] M_Z_LOW_OUT  = 27'd1 << 11;
  localparam logic [26:0] M_INPORT_OUT = 27'd1 << 10;
  localparam logic [26:0] M_C_OUT      = 27'd1 << 9;
  localparam logic [26:0] M_Y_IN       = 27'd1 << 8;
  localparam logic [26:0] M_MAR_IN     = 27'd1 << 7;
  localparam logic [26:0] M_OUTPORT_IN = 27'd1 << 6;
  localparam logic [26:0] M_MDR_IN     = 27'd1 << 5;
  localparam logic [26:0] M_MDR_OUT    = 27'd1 << 4;
  localparam logic [26:0] M_READ       = 27'd1 << 3;
  localparam logic [26:0] M_WRITE      = 27'd1 << 2;
  localparam logic [26:0] M_INC_PC     = 27'd1 << 1;
  localparam logic [26:0] M_CON_IN     = 27'd1 << 0;

  localparam logic [3:0] ALU_AND = 4'h0, ALU_OR  = 4'h1, ALU_ADD = 4'h2, ALU_SUB = 4'h3;
  localparam logic [3:0] ALU_SHR = 4'h4, ALU_SHL = 4'h5, ALU_ROR = 4'h6, ALU_ROL = 4'h7;
  localparam logic [3:0] ALU_MUL = 4'h8, ALU_DIV = 4'h9, ALU_NEG = 4'hA, ALU_NOT = 4'hB;

  localparam logic [4:0] OP_LD = 5'h00, OP_LDI = 5'h01, OP_ST = 5'h02, OP_BR = 5'h12;
  localparam logic [4:0] OP_JR = 5'h13, OP_JAL = 5'h14, OP_IN = 5'h15, OP_OUT = 5'h16;
  localparam logic [4:0] OP_MFHI = 5'h17, OP_MFLO = 5'h18, OP_HALT = 5'h1A, OP_ILL0 = 5'h1B;

  // Wait counter only needs to reach MEM_TO-1 before the timeout fires.
  localparam int WC_W = (MEM_TO > 1) ? $clog2(MEM_TO + 1) : 1;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_step, w_step_nxt;
  logic [WC_W-1:0]     r_wait_cnt;
  logic [ICNT_W-1:0]   r_icount;
  logic                r_bus_error, r_illegal_op;

  logic [4:0]          w_op;
  logic [2:0]          w_last;
  logic [26:0]         w_strb;
  logic [3:0]          w_alu;
  logic                w_mem_step, w_timeout, w_cnt_inc;
  logic                w_retire, w_set_bus_err, w_set_ill, w_clr_flags;
  logic                w_unused_ir;

  assign w_op        = i_ir_data[IR_W-1 -: 5];
  assign w_unused_ir = &{1'b0, i_ir_data[IR_W-6:0]};

  // Final execute step of each opcode.
  function automatic logic [2:0] last_step(input logic [4:0] op);
    case (op)
      5'h00, 5'h02:                             last_step = 3'd7;
      5'h0E, 5'h0F, 5'h12:                      last_step = 3'd6;
      5'h01, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
      5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D: last_step = 3'd5;
      5'h10, 5'h11, 5'h14:                      last_step = 3'd4;
      default:                                  last_step = 3'd3;
    endcase
  endfunction

  function automatic logic [3:0] op_alu(input logic [4:0] op);
    case (op)
      5'h03, 5'h0B: op_alu = ALU_ADD;
      5'h04:        op_alu = ALU_SUB;
      5'h05:        op_alu = ALU_SHR;
      5'h06:        op_alu = ALU_SHL;
      5'h07:        op_alu = ALU_ROR;
      5'h08:        op_alu = ALU_ROL;
      5'h09, 5'h0C: op_alu = ALU_AND;
      5'h0A, 5'h0D: op_alu = ALU_OR;
      5'h0E:        op_alu = ALU_MUL;
      5'h0F:        op_alu = ALU_DIV;
      5'h10:        op_alu = ALU_NEG;
      5'h11:        op_alu = ALU_NOT;
      default:      op_alu = ALU_ADD;
    endcase
  endfunction

  assign w_last = last_step(w_op);

  assign w_mem_step = (r_state == ST_F1) ||
                      ((r_state == ST_EX) && (((w_op == OP_LD) && (r_step == 3'd6)) ||
                                              ((w_op == OP_ST) && (r_step == 3'd7))));

  // Fires on the wait cycle that would make the count reach MEM_TO.
  assign w_timeout = (MEM_TO != 0) && (32'(r_wait_cnt) == 32'(MEM_TO - 1));
  assign w_cnt_inc = (MEM_TO != 0) && w_mem_step && !i_mem_ready && !w_timeout && !i_stop;

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_retire      = 1'b0;
    w_set_bus_err = 1'b0;
    w_set_ill     = 1'b0;
    w_clr_flags   = 1'b0;
    case (r_state)
      ST_BOUND: if (!i_step_en || i_step_req) w_state_nxt = ST_F0;
      ST_F0:    w_state_nxt = ST_F1;
      ST_F1: begin
        if (i_mem_ready) begin
          w_state_nxt = ST_F2;
        end else if (w_timeout) begin
          w_state_nxt   = ST_HALT;
          w_set_bus_err = 1'b1;
        end
      end
      ST_F2: begin
        w_state_nxt = ST_EX;
        w_step_nxt  = 3'd3;
      end
      ST_EX: begin
        if (w_op == OP_HALT) begin
          w_state_nxt = ST_HALT;
        end else if (w_op >= OP_ILL0) begin
          w_state_nxt = ST_HALT;
          w_set_ill   = 1'b1;
        end else if (w_mem_step && !i_mem_ready) begin
          if (w_timeout) begin
            w_state_nxt   = ST_HALT;
            w_set_bus_err = 1'b1;
          end
        end else if (r_step == w_last) begin
          w_state_nxt = ST_BOUND;
          w_retire    = 1'b1;
        end else begin
          w_step_nxt = r_step + 3'd1;
        end
      end
      ST_HALT: begin
        if (i_resume) begin
          w_state_nxt = ST_BOUND;
          w_clr_flags = 1'b1;
        end
      end
      default: w_state_nxt = ST_BOUND;
    endcase
    // Stop overrides everything: abort without retiring or touching flags.
    if (i_stop) begin
      w_state_nxt   = ST_HALT;
      w_retire      = 1'b0;
      w_set_bus_err = 1'b0;
      w_set_ill     = 1'b0;
      w_clr_flags   = 1'b0;
    end
  end

  // Strobe decode
  always_comb begin
    w_strb = '0;
    w_alu  = ALU_AND;
    case (r_state)
      ST_F0: begin
        w_strb = M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN;
        w_alu  = ALU_ADD;
      end
      ST_F1: w_strb = M_Z_LOW_OUT | M_PC_IN | M_READ | M_MDR_IN;
      ST_F2: w_strb = M_MDR_OUT | M_IR_IN;
      ST_EX: begin
        case (w_op)
          OP_LD, OP_LDI, OP_ST: begin
            case (r_step)
              3'd3: w_strb = M_GRB | M_BA_OUT | M_Y_IN;
              3'd4: begin
                w_strb = M_C_OUT | M_Z_IN;
                w_alu  = ALU_ADD;
              end
              3'd5: w_strb = (w_op == OP_LDI) ? (M_Z_LOW_OUT | M_GRA | M_R_IN)
                                              : (M_Z_LOW_OUT | M_MAR_IN);
              3'd6: w_strb = (w_op == OP_LD) ? (M_READ | M_MDR_IN)
                                             : (M_GRA | M_R_OUT | M_MDR_IN);
              3'd7: w_strb = (w_op == OP_LD) ? (M_MDR_OUT | M_GRA | M_R_IN) : M_WRITE;
              default: w_strb = '0;
            endcase
          end
          5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
          5'h0B, 5'h0C, 5'h0D: begin
            case (r_step)
              3'd3: w_strb = M_GRB | M_R_OUT | M_Y_IN;
              3'd4: begin
                // Immediate forms take the second operand from C instead of Rc.
                w_strb = (w_op >= 5'h0B) ? (M_C_OUT | M_Z_IN) : (M_GRC | M_R_OUT | M_Z_IN);
                w_alu  = op_alu(w_op);
              end
              3'd5: w_strb = M_Z_LOW_OUT | M_GRA | M_R_IN;
              default: w_strb = '0;
            endcase
          end
          5'h0E, 5'h0F: begin
            case (r_step)
              3'd3: w_strb = M_GRA | M_R_OUT | M_Y_IN;
              3'd4: begin
                w_strb = M_GRB | M_R_OUT | M_Z_IN;
                w_alu  = op_alu(w_op);
              end
              3'd5: w_strb = M_Z_LOW_OUT | M_LO_IN;
              3'd6: w_strb = M_Z_HIGH_OUT | M_HI_IN;
              default: w_strb = '0;
            endcase
          end
          5'h10, 5'h11: begin
            case (r_step)
              3'd3: begin
                w_strb = M_GRB | M_R_OUT | M_Z_IN;
                w_alu  = op_alu(w_op);
              end
              3'd4: w_strb = M_Z_LOW_OUT | M_GRA | M_R_IN;
              default: w_strb = '0;
            endcase
          end
          OP_BR: begin
            case (r_step)
              3'd3: w_strb = M_GRA | M_R_OUT | M_CON_IN;
              3'd4: w_strb = M_PC_OUT | M_Y_IN;
              3'd5: begin
                w_strb = M_C_OUT | M_Z_IN;
                w_alu  = ALU_ADD;
              end
              3'd6: w_strb = M_Z_LOW_OUT | (i_con_ff ? M_PC_IN : 27'd0);
              default: w_strb = '0;
            endcase
          end
          OP_JR:   if (r_step == 3'd3) w_strb = M_GRA | M_R_OUT | M_PC_IN;
          OP_JAL: begin
            if (r_step == 3'd3)      w_strb = M_R_IN | M_PC_OUT;
            else if (r_step == 3'd4) w_strb = M_GRA | M_R_OUT | M_PC_IN;
          end
          OP_IN:   if (r_step == 3'd3) w_strb = M_GRA | M_R_IN | M_INPORT_OUT;
          OP_OUT:  if (r_step == 3'd3) w_strb = M_GRA | M_R_OUT | M_OUTPORT_IN;
          OP_MFHI: if (r_step == 3'd3) w_strb = M_HI_OUT | M_GRA | M_R_IN;
          OP_MFLO: if (r_step == 3'd3) w_strb = M_LO_OUT | M_GRA | M_R_IN;
          default: w_strb = '0;  // nop, halt, illegal
        endcase
      end
      default: w_strb = '0;      // BOUND, HALT
    endcase
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_BOUND;
      r_step       <= 3'd0;
      r_wait_cnt   <= '0;
      r_icount     <= '0;
      r_bus_error  <= 1'b0;
      r_illegal_op <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_wait_cnt <= w_cnt_inc ? r_wait_cnt + 1'b1 : '0;
      if (w_retire) r_icount <= r_icount + 1'b1;
      if (w_clr_flags) begin
        r_bus_error  <= 1'b0;
        r_illegal_op <= 1'b0;
      end else begin
        if (w_set_bus_err) r_bus_error  <= 1'b1;
        if (w_set_ill)     r_illegal_op <= 1'b1;
      end
    end
  end

  assign o_gra        = w_strb[26];
  assign o_grb        = w_strb[25];
  assign o_grc        = w_strb[24];
  assign o_r_in       = w_strb[23];
  assign o_r_out      = w_strb[22];
  assign o_ba_out     = w_strb[21];
  assign o_hi_in      = w_strb[20];
  assign o_hi_out     = w_strb[19];
  assign o_lo_in      = w_strb[18];
  assign o_lo_out     = w_strb[17];
  assign o_pc_in      = w_strb[16];
  assign o_pc_out     = w_strb[15];
  assign o_ir_in      = w_strb[14];
  assign o_z_in       = w_strb[13];
  assign o_z_high_out = w_strb[12];
  assign o_z_low_out  = w_strb[11];
  assign o_inport_out = w_strb[10];
  assign o_c_out      = w_strb[9];
  assign o_y_in       = w_strb[8];
  assign o_mar_in     = w_strb[7];
  assign o_outport_in = w_strb[6];
  assign o_mdr_in     = w_strb[5];
  assign o_mdr_out    = w_strb[4];
  assign o_read       = w_strb[3];
  assign o_write      = w_strb[2];
  assign o_inc_pc     = w_strb[1];
  assign o_con_in     = w_strb[0];

  assign o_alu_op     = w_alu;
  assign o_run        = (r_state != ST_HALT);
  assign o_retired    = w_retire;
  assign o_icount     = r_icount;
  assign o_bus_error  = r_bus_error;
  assign o_illegal_op = r_illegal_op;
  assign o_dbg_state  = r_state;
  assign o_dbg_step   = r_step;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer. Instance A uses MEM_TO=15, ICNT_W=32;
// instance B uses MEM_TO=3, ICNT_W=2 for the timeout and counter-wrap cases.
// Both share every input. Inputs change just after a falling edge and
// outputs are sampled 1 ns after the falling edge.
module tb_ctrl_sequencer;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] ir;
  logic        con_ff, mem_ready, stop, resume, step_en, step_req;

  // Strobe order, MSB first: gra grb grc r_in r_out ba_out hi_in hi_out
  // lo_in lo_out pc_in pc_out ir_in z_in z_high_out z_low_out inport_out
  // c_out y_in mar_in outport_in mdr_in mdr_out read write inc_pc con_in
  localparam logic [26:0] GRA = 27'd1 << 26, GRB = 27'd1 << 25, GRC = 27'd1 << 24;
  localparam logic [26:0] R_IN = 27'd1 << 23, R_OUT = 27'd1 << 22, BA_OUT = 27'd1 << 21;
  localparam logic [26:0] LO_IN = 27'd1 << 18, PC_IN = 27'd1 << 16, PC_OUT = 27'd1 << 15;
  localparam logic [26:0] IR_IN = 27'd1 << 14, Z_IN = 27'd1 << 13, Z_LOW_OUT = 27'd1 << 11;
  localparam logic [26:0] C_OUT = 27'd1 << 9, Y_IN = 27'd1 << 8, MAR_IN = 27'd1 << 7;
  localparam logic [26:0] MDR_IN = 27'd1 << 5, MDR_OUT = 27'd1 << 4, READ = 27'd1 << 3;
  localparam logic [26:0] INC_PC = 27'd1 << 1, CON_IN = 27'd1 << 0;

  localparam logic [26:0] F0_S = PC_OUT | MAR_IN | INC_PC | Z_IN;
  localparam logic [26:0] F1_S = Z_LOW_OUT | PC_IN | READ | MDR_IN;
  localparam logic [26:0] F2_S = MDR_OUT | IR_IN;

  localparam logic [2:0] S_BOUND = 3'd0, S_F0 = 3'd1, S_F1 = 3'd2, S_EX = 3'd4, S_HALT = 3'd5;

  logic [26:0] a_strb, b_strb;
  logic [3:0]  a_alu, b_alu;
  logic        a_run, b_run, a_ret, b_ret, a_berr, b_berr, a_ill, b_ill;
  logic [31:0] a_icnt;
  logic [1:0]  b_icnt;
  logic [2:0]  a_st, b_st, a_step, b_step;

  ctrl_sequencer #(.IR_W(32), .MEM_TO(15), .ICNT_W(32)) u_dut_a (
    .i_clk(clk), .reset_n(reset_n), .i_ir_data(ir), .i_con_ff(con_ff),
    .i_mem_ready(mem_ready), .i_stop(stop), .i_resume(resume),
    .i_step_en(step_en), .i_step_req(step_req),
    .o_gra(a_strb[26]), .o_grb(a_strb[25]), .o_grc(a_strb[24]), .o_r_in(a_strb[23]),
    .o_r_out(a_strb[22]), .o_ba_out(a_strb[21]), .o_hi_in(a_strb[20]), .o_hi_out(a_strb[19]),
    .o_lo_in(a_strb[18]), .o_lo_out(a_strb[17]), .o_pc_in(a_strb[16]), .o_pc_out(a_strb[15]),
    .o_ir_in(a_strb[14]), .o_z_in(a_strb[13]), .o_z_high_out(a_strb[12]),
    .o_z_low_out(a_strb[11]), .o_inport_out(a_strb[10]), .o_c_out(a_strb[9]),
    .o_y_in(a_strb[8]), .o_mar_in(a_strb[7]), .o_outport_in(a_strb[6]), .o_mdr_in(a_strb[5]),
    .o_mdr_out(a_strb[4]), .o_read(a_strb[3]), .o_write(a_strb[2]), .o_inc_pc(a_strb[1]),
    .o_con_in(a_strb[0]), .o_alu_op(a_alu), .o_run(a_run), .o_retired(a_ret),
    .o_icount(a_icnt), .o_bus_error(a_berr), .o_illegal_op(a_ill),
    .o_dbg_state(a_st), .o_dbg_step(a_step)
  );

  ctrl_sequencer #(.IR_W(32), .MEM_TO(3), .ICNT_W(2)) u_dut_b (
    .i_clk(clk), .reset_n(reset_n), .i_ir_data(ir), .i_con_ff(con_ff),
    .i_mem_ready(mem_ready), .i_stop(stop), .i_resume(resume),
    .i_step_en(step_en), .i_step_req(step_req),
    .o_gra(b_strb[26]), .o_grb(b_strb[25]), .o_grc(b_strb[24]), .o_r_in(b_strb[23]),
    .o_r_out(b_strb[22]), .o_ba_out(b_strb[21]), .o_hi_in(b_strb[20]), .o_hi_out(b_strb[19]),
    .o_lo_in(b_strb[18]), .o_lo_out(b_strb[17]), .o_pc_in(b_strb[16]), .o_pc_out(b_strb[15]),
    .o_ir_in(b_strb[14]), .o_z_in(b_strb[13]), .o_z_high_out(b_strb[12]),
    .o_z_low_out(b_strb[11]), .o_inport_out(b_strb[10]), .o_c_out(b_strb[9]),
    .o_y_in(b_strb[8]), .o_mar_in(b_strb[7]), .o_outport_in(b_strb[6]), .o_mdr_in(b_strb[5]),
    .o_mdr_out(b_strb[4]), .o_read(b_strb[3]), .o_write(b_strb[2]), .o_inc_pc(b_strb[1]),
    .o_con_in(b_strb[0]), .o_alu_op(b_alu), .o_run(b_run), .o_retired(b_ret),
    .o_icount(b_icnt), .o_bus_error(b_berr), .o_illegal_op(b_ill),
    .o_dbg_state(b_st), .o_dbg_step(b_step)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver helpers
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [26:0] s, input logic [3:0] alu);
    check({tag, " strb"}, 32'(a_strb), 32'(s));
    check({tag, " alu"}, 32'(a_alu), 32'(alu));
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    mk_ir = {op, 27'h0};
  endfunction

  initial begin
    reset_n = 1'b0; ir = mk_ir(5'h03); con_ff = 1'b0; mem_ready = 1'b1;
    stop = 1'b0; resume = 1'b0; step_en = 1'b0; step_req = 1'b0;

    // Reset state
    adv(2);
    chk_a("rst", 27'd0, 4'h0);
    check("rst run", 32'(a_run), 32'd1);
    check("rst retired", 32'(a_ret), 32'd0);
    check("rst icount", a_icnt, 32'd0);
    check("rst bus_error", 32'(a_berr), 32'd0);
    check("rst illegal", 32'(a_ill), 32'd0);
    check("rst state", 32'(a_st), 32'(S_BOUND));
    reset_n = 1'b1;

    // add R1,R2,R3: 7 cycles BOUND..T5
    adv(1); chk_a("add F0", F0_S, 4'h2);
    adv(1); chk_a("add F1", F1_S, 4'h0);
    adv(1); chk_a("add F2", F2_S, 4'h0);
    adv(1); chk_a("add T3", GRB | R_OUT | Y_IN, 4'h0);
    adv(1); chk_a("add T4", GRC | R_OUT | Z_IN, 4'h2);
    adv(1); chk_a("add T5", Z_LOW_OUT | GRA | R_IN, 4'h0);
    check("add T5 retired", 32'(a_ret), 32'd1);
    check("add T5 icount", a_icnt, 32'd0);
    adv(1); chk_a("add end", 27'd0, 4'h0);
    check("add end state", 32'(a_st), 32'(S_BOUND));
    check("add end retired", 32'(a_ret), 32'd0);
    check("add end icount", a_icnt, 32'd1);
    ir = mk_ir(5'h00);

    // ld with four wait cycles in T6
    adv(1); chk_a("ld F0", F0_S, 4'h2);
    adv(2); chk_a("ld F2", F2_S, 4'h0);
    adv(1); chk_a("ld T3", GRB | BA_OUT | Y_IN, 4'h0);
    adv(1); chk_a("ld T4", C_OUT | Z_IN, 4'h2);
    adv(1); chk_a("ld T5", Z_LOW_OUT | MAR_IN, 4'h0);
    for (int i = 0; i < 5; i++) begin
      adv(1);
      mem_ready = (i == 4);
      chk_a($sformatf("ld T6 c%0d", i), READ | MDR_IN, 4'h0);
      check($sformatf("ld T6 step c%0d", i), 32'(a_step), 32'd6);
      check($sformatf("ld T6 berr c%0d", i), 32'(a_berr), 32'd0);
    end
    adv(1); chk_a("ld T7", MDR_OUT | GRA | R_IN, 4'h0);
    check("ld T7 retired", 32'(a_ret), 32'd1);
    adv(1);
    check("ld end state", 32'(a_st), 32'(S_BOUND));
    check("ld end icount", a_icnt, 32'd2);
    check("ld end berr", 32'(a_berr), 32'd0);
    ir = mk_ir(5'h12); con_ff = 1'b0;

    // br not taken, then taken
    adv(4); chk_a("br0 T3", GRA | R_OUT | CON_IN, 4'h0);
    adv(1); chk_a("br0 T4", PC_OUT | Y_IN, 4'h0);
    adv(1); chk_a("br0 T5", C_OUT | Z_IN, 4'h2);
    adv(1); chk_a("br0 T6", Z_LOW_OUT, 4'h0);
    check("br0 T6 retired", 32'(a_ret), 32'd1);
    adv(1); check("br0 end icount", a_icnt, 32'd3);
    con_ff = 1'b1;
    adv(7); chk_a("br1 T6", Z_LOW_OUT | PC_IN, 4'h0);
    adv(1); check("br1 end state", 32'(a_st), 32'(S_BOUND));
    check("br1 end icount", a_icnt, 32'd4);
    ir = mk_ir(5'h1E);

    // Illegal opcode 1E
    adv(4); chk_a("ill T3", 27'd0, 4'h0);
    adv(1);
    check("ill state", 32'(a_st), 32'(S_HALT));
    check("ill flag", 32'(a_ill), 32'd1);
    check("ill run", 32'(a_run), 32'd0);
    check("ill icount", a_icnt, 32'd4);
    chk_a("ill halt", 27'd0, 4'h0);
    // resume is ignored while stop is high
    stop = 1'b1; resume = 1'b1;
    adv(1);
    check("halt stop+resume state", 32'(a_st), 32'(S_HALT));
    check("halt stop+resume flag", 32'(a_ill), 32'd1);
    stop = 1'b0;
    adv(1); resume = 1'b0;
    check("resume state", 32'(a_st), 32'(S_BOUND));
    check("resume flag", 32'(a_ill), 32'd0);
    check("resume run", 32'(a_run), 32'd1);
    ir = mk_ir(5'h0E);

    // mul aborted by stop in T4
    adv(4); chk_a("mul T3", GRA | R_OUT | Y_IN, 4'h0);
    adv(1); chk_a("mul T4", GRB | R_OUT | Z_IN, 4'h8);
    stop = 1'b1;
    adv(1);
    chk_a("mul stop", 27'd0, 4'h0);
    check("mul stop state", 32'(a_st), 32'(S_HALT));
    check("mul stop icount", a_icnt, 32'd4);
    check("mul stop run", 32'(a_run), 32'd0);
    stop = 1'b0; resume = 1'b1;
    adv(1); resume = 1'b0;
    check("mul resume state", 32'(a_st), 32'(S_BOUND));
    step_en = 1'b1; ir = mk_ir(5'h19);

    // Single-step: two step_req pulses, one extra pulse mid-instruction
    adv(3);
    check("ss idle state", 32'(a_st), 32'(S_BOUND));
    check("ss idle icount", a_icnt, 32'd4);
    step_req = 1'b1;
    adv(1); step_req = 1'b0;
    check("ss1 F0", 32'(a_st), 32'(S_F0));
    adv(1); step_req = 1'b1;
    check("ss1 F1", 32'(a_st), 32'(S_F1));
    adv(1); step_req = 1'b0;
    adv(1); chk_a("ss1 T3", 27'd0, 4'h0);
    check("ss1 T3 retired", 32'(a_ret), 32'd1);
    adv(4);
    check("ss1 wait state", 32'(a_st), 32'(S_BOUND));
    check("ss1 wait icount", a_icnt, 32'd5);
    step_req = 1'b1;
    adv(1); step_req = 1'b0;
    adv(4);
    check("ss2 wait state", 32'(a_st), 32'(S_BOUND));
    adv(2);
    check("ss2 still bound", 32'(a_st), 32'(S_BOUND));
    check("ss2 icount", a_icnt, 32'd6);

    // Timeout on instance B (MEM_TO=3) with mem_ready stuck low in ld T6
    step_en = 1'b0; ir = mk_ir(5'h00); mem_ready = 1'b1;
    reset_n = 1'b0; adv(1); reset_n = 1'b1;
    adv(6); mem_ready = 1'b0;
    adv(3);
    check("to wait3 run", 32'(b_run), 32'd1);
    check("to wait3 berr", 32'(b_berr), 32'd0);
    adv(1);
    check("to berr", 32'(b_berr), 32'd1);
    check("to run", 32'(b_run), 32'd0);
    check("to state", 32'(b_st), 32'(S_HALT));
    check("to strb", 32'(b_strb), 32'd0);
    check("to A still waiting", 32'(a_strb), 32'(READ | MDR_IN));
    check("to A berr", 32'(a_berr), 32'd0);
    resume = 1'b1;
    adv(1); resume = 1'b0;
    check("to resume state", 32'(b_st), 32'(S_BOUND));
    check("to resume berr", 32'(b_berr), 32'd0);
    check("to resume run", 32'(b_run), 32'd1);

    // Five nops: icount wraps on the 2-bit instance
    ir = mk_ir(5'h19); mem_ready = 1'b1;
    reset_n = 1'b0; adv(1); reset_n = 1'b1;
    adv(25);
    check("nop5 A icount", a_icnt, 32'd5);
    check("nop5 B icount", 32'(b_icnt), 32'd1);
    check("nop5 state", 32'(a_st), 32'(S_BOUND));

    // Asynchronous reset mid-instruction
    adv(2);
    check("arst pre state", 32'(a_st), 32'(S_F1));
    reset_n = 1'b0;
    #1;
    check("arst state", 32'(a_st), 32'(S_BOUND));
    check("arst icount", a_icnt, 32'd0);
    check("arst strb", 32'(a_strb), 32'd0);
    check("arst B icount", 32'(b_icnt), 32'd0);
    adv(1); reset_n = 1'b1;
    adv(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
